pipelined_adder_nbit: RTL and testbench

Parametrised N-bit ripple-carry adder, split into NUM_STAGES registered chunks so it closes timing at wide widths. Each stage adds one CHUNK = NUM_BITS/NUM_STAGES slice and passes the carry to the next stage through a register. Valid/ready handshakes on input and output give one result per cycle when unstalled. Serves as the datapath adder in front of accumulator/ALU blocks that consume a stream of operand pairs.

---
 rtl/pipelined_adder_nbit.sv | 106 ++++++++++
 tb/tb_pipelined_adder_nbit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder_nbit.sv
// Pipelined N-bit ripple-carry adder: each stage adds one CHUNK-wide slice and registers
// its carry for the next stage. All stages share one advance/stall signal.
module pipelined_adder_nbit #(
   parameter int NUM_BITS   = 16,
   parameter int NUM_STAGES = 4
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic [NUM_BITS-1:0] a,
   input  logic [NUM_BITS-1:0] b,
   input  logic                carry_in,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [NUM_BITS-1:0] sum,
   output logic                carry_out,
   output logic                overflow,
   output logic                out_valid,
   input  logic                out_ready
);
   localparam int CHUNK = NUM_BITS / NUM_STAGES;
   localparam int LAST  = NUM_STAGES - 1;

   logic advance;

   // No bubble collapsing: the whole pipe moves or the whole pipe holds.
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
      // IN_W: operand bits still unconsumed on entry to this stage.
      // RES_W: result bits already formed on exit from this stage.
      localparam int IN_W  = NUM_BITS - k * CHUNK;
      localparam int RES_W = (k + 1) * CHUNK;

      logic [IN_W-1:0]  a_in;
      logic [IN_W-1:0]  b_in;
      logic             c_in;
      logic             v_in;
      logic [CHUNK:0]   add;
      logic [RES_W-1:0] r_next;
      logic [RES_W-1:0] r_q;
      logic             c_q;
      logic             v_q;

      if (k == 0) begin : g_src
         assign a_in   = a;
         assign b_in   = b;
         assign c_in   = carry_in;
         assign v_in   = in_valid;
         assign r_next = add[CHUNK-1:0];
      end else begin : g_src
         assign a_in   = g_stage[k-1].g_fwd.a_q;
         assign b_in   = g_stage[k-1].g_fwd.b_q;
         assign c_in   = g_stage[k-1].c_q;
         assign v_in   = g_stage[k-1].v_q;
         assign r_next = {add[CHUNK-1:0], g_stage[k-1].r_q};
      end

      assign add = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, c_in};

      always_ff @(posedge clk or negedge n_rst) begin
         if (!n_rst) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            r_q <= '0;
         end else if (advance) begin
            v_q <= v_in;
            c_q <= add[CHUNK];
            r_q <= r_next;
         end
      end

      if (k < LAST) begin : g_fwd
         logic [IN_W-CHUNK-1:0] a_q;
         logic [IN_W-CHUNK-1:0] b_q;

         always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
               a_q <= '0;
               b_q <= '0;
            end else if (advance) begin
               a_q <= a_in[IN_W-1:CHUNK];
               b_q <= b_in[IN_W-1:CHUNK];
            end
         end
      end else begin : g_msb
         // Carry into the MSB, recovered from the MSB's own sum bit.
         logic msb_c_q;

         always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
               msb_c_q <= 1'b0;
            end else if (advance) begin
               msb_c_q <= a_in[CHUNK-1] ^ b_in[CHUNK-1] ^ add[CHUNK-1];
            end
         end
      end
   end

   assign out_valid = g_stage[LAST].v_q;
   assign sum       = g_stage[LAST].r_q;
   assign carry_out = g_stage[LAST].c_q;
   assign overflow  = g_stage[LAST].g_msb.msb_c_q ^ g_stage[LAST].c_q;

endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// Scoreboard bench for pipelined_adder_nbit: the driver records expected results at
// acceptance, and the monitor checks data, latency and stall hold on every output transfer.
module tb_pipelined_adder_nbit;
   localparam int NB = 16;
   localparam int NS = 4;

   logic          clk = 1'b0;
   logic          n_rst = 1'b0;
   logic [NB-1:0] a = '0;
   logic [NB-1:0] b = '0;
   logic          carry_in = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [NB-1:0] sum;
   logic          carry_out;
   logic          overflow;
   logic          out_valid;
   logic          out_ready = 1'b1;

   pipelined_adder_nbit #(.NUM_BITS(NB), .NUM_STAGES(NS)) dut (
      .clk(clk), .n_rst(n_rst), .a(a), .b(b), .carry_in(carry_in),
      .in_valid(in_valid), .in_ready(in_ready), .sum(sum), .carry_out(carry_out),
      .overflow(overflow), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NB-1:0] s;
      logic          c;
      logic          o;
      int            cyc;
      int            stl;
   } exp_t;

   exp_t          exp_q[$];
   int            errors = 0;
   int            checks = 0;
   int            cyc = 0;
   int            stall_cnt = 0;
   int            n_out = 0;
   int            n_exp = 0;
   logic [NB-1:0] exp_sum = '0;
   logic          exp_c = 1'b0;
   logic          exp_o = 1'b0;
   logic          hold_prev = 1'b0;
   logic [NB-1:0] prev_sum = '0;
   logic          prev_c = 1'b0;
   logic          prev_o = 1'b0;

   // Directed vectors: a, b, cin, hand-computed sum, carry_out, overflow.
   localparam logic [NB-1:0] DA[7] = '{16'h7FFF, 16'hFFFF, 16'h00FF, 16'h8000, 16'hAAAA, 16'h1234, 16'h7FFF};
   localparam logic [NB-1:0] DB[7] = '{16'h0001, 16'h0001, 16'h0000, 16'h8000, 16'h5555, 16'h4321, 16'h7FFF};
   localparam logic          DI[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
   localparam logic [NB-1:0] DS[7] = '{16'h8000, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'h5555, 16'hFFFF};
   localparam logic          DC[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
   localparam logic          DO[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      exp_t e;
      if (n_rst) begin
         if (hold_prev) begin
            check("hold_valid", {31'b0, out_valid}, 32'd1);
            check("hold_sum", {16'b0, sum}, {16'b0, prev_sum});
            check("hold_carry", {31'b0, carry_out}, {31'b0, prev_c});
            check("hold_ovf", {31'b0, overflow}, {31'b0, prev_o});
         end
         if (out_valid && !out_ready) check("stall_in_ready", {31'b0, in_ready}, 32'd0);
         if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got sum 0x%0h, expected no output", sum);
            end else begin
               e = exp_q.pop_front();
               check("sum", {16'b0, sum}, {16'b0, e.s});
               check("carry_out", {31'b0, carry_out}, {31'b0, e.c});
               check("overflow", {31'b0, overflow}, {31'b0, e.o});
               check("latency", cyc - e.cyc, NS + stall_cnt - e.stl);
            end
         end
         if (in_valid && in_ready) begin
            e.s   = exp_sum;
            e.c   = exp_c;
            e.o   = exp_o;
            e.cyc = cyc;
            e.stl = stall_cnt;
            exp_q.push_back(e);
            n_exp++;
         end
         hold_prev = out_valid && !out_ready;
         prev_sum  = sum;
         prev_c    = carry_out;
         prev_o    = overflow;
         if (!in_ready) stall_cnt++;
      end else begin
         hold_prev = 1'b0;
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; returns at posedge+1 after the edge that accepted the operands.
   task automatic send(input logic [NB-1:0] av, input logic [NB-1:0] bv, input logic ci,
                       input logic [NB-1:0] es, input logic ec, input logic eo);
      int  n;
      bit  done;
      a        = av;
      b        = bv;
      carry_in = ci;
      exp_sum  = es;
      exp_c    = ec;
      exp_o    = eo;
      in_valid = 1'b1;
      n        = 0;
      done     = 1'b0;
      while (!done) begin
         @(negedge clk);
         done = in_ready;
         @(posedge clk);
         #1;
         n++;
         if (!done && n > 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck at %0d, expected 1", in_ready);
            done = 1'b1;
         end
      end
   endtask

   task automatic send_model(input logic [NB-1:0] av, input logic [NB-1:0] bv, input logic ci);
      logic [NB:0] t;
      t = {1'b0, av} + {1'b0, bv} + {{NB{1'b0}}, ci};
      send(av, bv, ci, t[NB-1:0], t[NB], (av[NB-1] == bv[NB-1]) && (t[NB-1] != av[NB-1]));
   endtask

   task automatic drain();
      int n;
      in_valid = 1'b0;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         cycles(1);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      end
      cycles(2);
   endtask

   task automatic send_stream(input int n);
      for (int i = 0; i < n; i++)
         send_model(NB'($urandom), NB'($urandom), 1'($urandom));
      in_valid = 1'b0;
   endtask

   initial begin
      #12;
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_sum", {16'b0, sum}, 32'd0);
      check("rst_carry", {31'b0, carry_out}, 32'd0);
      check("rst_ovf", {31'b0, overflow}, 32'd0);
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      cycles(2);

      for (int i = 0; i < 7; i++) begin
         send(DA[i], DB[i], DI[i], DS[i], DC[i], DO[i]);
         drain();
      end

      send_stream(20);
      drain();

      fork
         send_stream(20);
         begin
            cycles(8);
            out_ready = 1'b0;
            cycles(3);
            out_ready = 1'b1;
         end
      join
      drain();

      for (int i = 0; i < 3; i++)
         send_model(NB'($urandom), NB'($urandom), 1'($urandom));
      in_valid = 1'b0;
      n_rst    = 1'b0;
      #1;
      check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
      check("midrst_sum", {16'b0, sum}, 32'd0);
      check("midrst_carry", {31'b0, carry_out}, 32'd0);
      check("midrst_ovf", {31'b0, overflow}, 32'd0);
      n_exp -= exp_q.size();
      exp_q.delete();
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      cycles(1);
      send(16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0);
      drain();

      check("out_count", n_out, n_exp);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
